alu_issue: RTL and testbench
============================

# alu_issue

Single-issue instruction sequencer that sits directly upstream of the 16-bit ALU. It accepts 16-bit instruction words over a valid/ready handshake and decodes them. It reads operands from an 8×16 register file and drives the ALU's `en`/`op`/`op1`/`op2` inputs. It then writes the ALU `result` and carry flag back into architectural state.

## Interface
Parameters:
- `NREGS`, 8: register count; fixed at 8 because of the 3-bit register fields.
- `W`, 16: data width; must match the ALU.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `instr_valid`  in  1  `instr` is valid.
- `instr_ready`  out  1  the block can accept an instruction; high only in IDLE.
- `instr`  in  16  instruction word.
- `alu_en`  out  1  high only in EXEC.
- `alu_op`  out  operation_t  ALU operation, registered.
- `alu_op1`, `alu_op2`  out  16  operands, registered.
- `alu_result`  in  16  ALU result, combinational from the ALU.
- `alu_fls`  in  flags_t  ALU flags; only `carry` is used.
- `carry_flag`  out  1  architectural carry.
- `illegal`  out  1  sticky flag: an illegal opcode was seen.
- `dbg_addr`  in  3  debug read address.
- `dbg_data`  out  16  combinational read of `reg[dbg_addr]`.

## Operation
Instruction encoding:
- Bits [15:13] opcode, [12:10] rd, [9:7] rs1, [6:4] rs2.
- Opcodes: 0 NOP, 1 ADD, 2 SUB, 3 GTE, 4 LT, 5 NOT (uses rs1 only), 6 LDI, 7 illegal.
- LDI: rd ← zero-extended `instr[9:0]`.

Register file:
- r0 reads 0; writes to r0 are discarded.
- r1–r7 reset to 0.

FSM states IDLE, EXEC, WB:
- IDLE: `instr_ready`=1. On `instr_valid`:
  - NOP: no effect; stay in IDLE.
  - Opcode 7: set `illegal`; stay in IDLE.
  - LDI: latch rd and the immediate into `res_q`; go to WB.
  - ALU ops: latch rd, `alu_op`, `alu_op1`←reg[rs1], `alu_op2`←reg[rs2]; go to EXEC.
- EXEC: `alu_en`=1. At the clock edge, capture `alu_result` into `res_q` and `alu_fls.carry` into `cy_q`; go to WB.
- WB: write reg[rd] and update `carry_flag`; go to IDLE.

Result mapping:
- ADD, SUB, NOT: write `res_q`.
- GTE: write 16'h0001 if `cy_q`=0, else 16'h0000.
- LT: write 16'h0001 if `cy_q`=1, else 16'h0000.

Carry flag:
- `carry_flag`←`cy_q` for ADD, SUB, GTE, LT.
- NOT, LDI, NOP and illegal leave it unchanged. `alu_fls` is ignored for NOT.

Reset values:
- FSM in IDLE.
- All registers 0.
- `alu_en`=0, `alu_op`=ADD, `alu_op1`=`alu_op2`=0.
- `carry_flag`=0, `illegal`=0.
- `illegal` clears only on reset.

## Timing
- Acceptance happens at the rising edge where `instr_valid`&&`instr_ready`.
- ALU op accepted at edge E0:
  - EXEC during the cycle E0→E1.
  - Result captured at E1.
  - reg[rd] and `carry_flag` updated at E2.
  - `instr_ready` high again after E2.
  - Throughput: 1 instruction per 3 cycles.
- LDI: write at E1; 1 per 2 cycles.
- NOP and illegal: 1 per cycle.
- `instr_ready` is a combinational decode of state; `instr` is sampled only at acceptance.
- There are no hazards. Operands are read at acceptance, after any prior write has completed, so back-to-back dependent instructions see updated values.
- `dbg_data` reflects a write from the cycle after the write edge.
- Reset asserted mid-EXEC or mid-WB: FSM goes to IDLE immediately, the pending write is lost, and all state is zeroed.

## Structure
- Shared package `ptype` holds `operation_t`, `flags_t` and a new `opcode_t` enum (NOP…ILL, 3 bits).
- Instruction field-position localparams also live in `ptype`.
- One sub-module: `alu_regfile` with 8×16 storage, r0 hardwired to zero, three asynchronous read ports (rs1, rs2, dbg) and one synchronous write port with asynchronous reset.
- The FSM, decode and result mapping stay in `alu_issue`.

## Test plan
- Reset: pulse `rst` → every `dbg_data` read returns 0; `instr_ready`=1, `carry_flag`=0, `alu_en`=0.
- Add sequence: LDI r1,0x3FF; LDI r2,0x001; ADD r3,r1,r2 → r3=16'h0400 and `carry_flag`=0. Check that `alu_en` is high for exactly one cycle and r3 is written 2 edges after acceptance.
- Overflow and compare:
  - NOT r4,r0 → r4=16'hFFFF.
  - ADD r5,r4,r2 → r5=0, `carry_flag`=1.
  - SUB r7,r2,r1 → r7=16'hFC02, carry=1.
  - GTE r6,r1,r2 → 1, carry=0.
  - LT r6,r1,r2 → 0.
  - NOT r4,r1 → carry unchanged.
- Boundaries:
  - LDI r0,5 → r0 reads 0.
  - Opcode 7 → `illegal`=1 and stays 1, no register change.
  - NOP → no change, accepted every cycle.
- Backpressure: hold `instr_valid`=1 over mixed traffic → acceptances every 3 cycles for ALU ops, 2 for LDI, 1 for NOP; no instruction dropped or duplicated.
- Reset mid-operation: assert `rst` during EXEC of ADD r3 → r3 never written, FSM in IDLE, `instr_ready`=1 during reset.

Source files
------------

// File: rtl/ptype.sv
// Shared types for the ALU and its issue sequencer: ALU operations, flags,
// instruction opcodes and instruction field positions.
package ptype;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_GTE = 3'd2,
    OP_LT  = 3'd3,
    OP_NOT = 3'd4
  } operation_t;

  typedef struct packed {
    logic carry;
    logic zero;
  } flags_t;

  typedef enum logic [2:0] {
    OPC_NOP = 3'd0,
    OPC_ADD = 3'd1,
    OPC_SUB = 3'd2,
    OPC_GTE = 3'd3,
    OPC_LT  = 3'd4,
    OPC_NOT = 3'd5,
    OPC_LDI = 3'd6,
    OPC_ILL = 3'd7
  } opcode_t;

  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int IMM_MSB = 9;
  localparam int IMM_W   = IMM_MSB + 1;

  function automatic operation_t opc_to_op(input opcode_t opc);
    case (opc)
      OPC_SUB: return OP_SUB;
      OPC_GTE: return OP_GTE;
      OPC_LT:  return OP_LT;
      OPC_NOT: return OP_NOT;
      default: return OP_ADD;
    endcase
  endfunction

endpackage

// File: rtl/alu_regfile.sv
// 8x16 architectural register file: r0 hardwired to zero, three
// asynchronous read ports and one synchronous write port.
module alu_regfile #(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   rs1_addr,
  input  logic [2:0]   rs2_addr,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] rs1_data,
  output logic [W-1:0] rs2_data,
  output logic [W-1:0] dbg_data,
  input  logic         we,
  input  logic [2:0]   wr_addr,
  input  logic [W-1:0] wr_data
);

  logic [NREGS-1:0][W-1:0] rf;

  // No storage exists for r0, so writes to it fall away naturally.
  assign rf[0] = '0;

  generate
    for (genvar gi = 1; gi < NREGS; gi++) begin : g_reg
      logic [W-1:0] q_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          q_reg <= '0;
        end else if (we && (wr_addr == 3'(gi))) begin
          q_reg <= wr_data;
        end
      end
      assign rf[gi] = q_reg;
    end
  endgenerate

  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];
  assign dbg_data = rf[dbg_addr];

endmodule

// File: rtl/alu_issue.sv
// Single-issue sequencer in front of the 16-bit ALU: accept, decode, read
// operands, drive the ALU for one cycle, then write back result and carry.
module alu_issue
  import ptype::*;
#(
  parameter int NREGS = 8,
  parameter int W     = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         instr_valid,
  output logic         instr_ready,
  input  logic [15:0]  instr,
  output logic         alu_en,
  output operation_t   alu_op,
  output logic [W-1:0] alu_op1,
  output logic [W-1:0] alu_op2,
  input  logic [W-1:0] alu_result,
  input  flags_t       alu_fls,
  output logic         carry_flag,
  output logic         illegal,
  input  logic [2:0]   dbg_addr,
  output logic [W-1:0] dbg_data
);

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_WB} state_t;

  state_t       state_reg;
  opcode_t      opc_reg;
  logic [2:0]   rd_reg;
  logic [W-1:0] res_q;
  logic         cy_q;

  opcode_t      opc;
  logic [W-1:0] rs1_data;
  logic [W-1:0] rs2_data;
  logic [W-1:0] wb_data;
  logic         unused_flags;

  assign opc          = opcode_t'(instr[OPC_MSB:OPC_LSB]);
  assign instr_ready  = (state_reg == S_IDLE);
  assign unused_flags = alu_fls.zero;

  // Compares turn the ALU borrow into a boolean; everything else writes res_q.
  always_comb begin
    wb_data = res_q;
    case (opc_reg)
      OPC_GTE: wb_data = {{(W-1){1'b0}}, ~cy_q};
      OPC_LT:  wb_data = {{(W-1){1'b0}}, cy_q};
      default: wb_data = res_q;
    endcase
  end

  alu_regfile #(.NREGS(NREGS), .W(W)) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (instr[RS1_MSB:RS1_LSB]),
    .rs2_addr (instr[RS2_MSB:RS2_LSB]),
    .dbg_addr (dbg_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .dbg_data (dbg_data),
    .we       (state_reg == S_WB),
    .wr_addr  (rd_reg),
    .wr_data  (wb_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      opc_reg    <= OPC_NOP;
      rd_reg     <= '0;
      res_q      <= '0;
      cy_q       <= 1'b0;
      alu_en     <= 1'b0;
      alu_op     <= OP_ADD;
      alu_op1    <= '0;
      alu_op2    <= '0;
      carry_flag <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (instr_valid) begin
            case (opc)
              OPC_NOP: ;
              OPC_ILL: illegal <= 1'b1;
              OPC_LDI: begin
                opc_reg   <= opc;
                rd_reg    <= instr[RD_MSB:RD_LSB];
                res_q     <= {{(W-IMM_W){1'b0}}, instr[IMM_MSB:0]};
                state_reg <= S_WB;
              end
              default: begin
                opc_reg   <= opc;
                rd_reg    <= instr[RD_MSB:RD_LSB];
                alu_op    <= opc_to_op(opc);
                alu_op1   <= rs1_data;
                alu_op2   <= rs2_data;
                alu_en    <= 1'b1;
                state_reg <= S_EXEC;
              end
            endcase
          end
        end
        S_EXEC: begin
          res_q     <= alu_result;
          cy_q      <= alu_fls.carry;
          alu_en    <= 1'b0;
          state_reg <= S_WB;
        end
        S_WB: begin
          if (opc_reg inside {OPC_ADD, OPC_SUB, OPC_GTE, OPC_LT}) begin
            carry_flag <= cy_q;
          end
          state_reg <= S_IDLE;
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: behavioural ALU, transaction-level reference model,
// directed literal checks and randomized traffic.
module tb_alu_issue;
  import ptype::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         instr_valid = 1'b0;
  logic         instr_ready;
  logic [15:0]  instr = '0;
  logic         alu_en;
  operation_t   alu_op;
  logic [15:0]  alu_op1, alu_op2, alu_result;
  flags_t       alu_fls;
  logic         carry_flag, illegal;
  logic [2:0]   dbg_addr = '0;
  logic [15:0]  dbg_data;
  logic         nc = 1'b0;

  always #5 clk = ~clk;

  alu_issue #(.NREGS(8), .W(16)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .alu_en(alu_en), .alu_op(alu_op), .alu_op1(alu_op1),
    .alu_op2(alu_op2), .alu_result(alu_result), .alu_fls(alu_fls),
    .carry_flag(carry_flag), .illegal(illegal), .dbg_addr(dbg_addr),
    .dbg_data(dbg_data)
  );

  // External ALU: carry is carry-out for ADD and borrow for subtract-type ops.
  always_comb begin
    alu_fls    = '0;
    alu_result = '0;
    case (alu_op)
      OP_ADD: {alu_fls.carry, alu_result} = {1'b0, alu_op1} + {1'b0, alu_op2};
      OP_SUB, OP_GTE, OP_LT: begin
        alu_result    = alu_op1 - alu_op2;
        alu_fls.carry = (alu_op1 < alu_op2);
      end
      OP_NOT: begin
        alu_result    = ~alu_op1;
        alu_fls.carry = nc;
      end
      default: ;
    endcase
    alu_fls.zero = (alu_result == 16'h0000);
  end

  // Reference model: architectural state plus one pending write with latency.
  logic [15:0] m_reg [8];
  logic        m_cy, m_ill;
  int          m_pend;
  bit          m_isalu, m_updc, m_cynew;
  logic [2:0]  m_rd;
  logic [15:0] m_val, m_op1, m_op2;

  int n_tests = 0;
  int n_fail  = 0;
  int en_cnt  = 0;
  bit chk_en  = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_reg[i] = '0;
    m_cy = 0; m_ill = 0; m_pend = 0; m_isalu = 0; m_updc = 0;
    m_cynew = 0; m_rd = '0; m_val = '0; m_op1 = '0; m_op2 = '0;
  endtask

  task automatic model_edge();
    logic [2:0]  op;
    logic [15:0] a, b;
    logic [16:0] sum;
    if (rst) begin
      model_reset();
    end else if (m_pend > 0) begin
      m_pend--;
      if (m_pend == 0) begin
        if (m_rd != 0) m_reg[m_rd] = m_val;
        if (m_updc) m_cy = m_cynew;
      end
    end else if (instr_valid) begin
      op = instr[15:13];
      a  = m_reg[instr[9:7]];
      b  = m_reg[instr[6:4]];
      m_rd = instr[12:10];
      m_op1 = a; m_op2 = b;
      m_isalu = 1; m_updc = 1; m_cynew = (a < b);
      case (op)
        3'd0: ;
        3'd7: m_ill = 1;
        3'd6: begin m_val = {6'b0, instr[9:0]}; m_isalu = 0; m_updc = 0; m_pend = 1; end
        3'd1: begin sum = {1'b0, a} + {1'b0, b}; m_val = sum[15:0]; m_cynew = sum[16]; m_pend = 2; end
        3'd2: begin m_val = a - b; m_pend = 2; end
        3'd3: begin m_val = (a >= b) ? 16'd1 : 16'd0; m_pend = 2; end
        3'd4: begin m_val = (a < b) ? 16'd1 : 16'd0; m_pend = 2; end
        default: begin m_val = ~a; m_updc = 0; m_pend = 2; end
      endcase
    end
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("ready", {31'b0, instr_ready}, {31'b0, m_pend == 0});
      chk("alu_en", {31'b0, alu_en}, {31'b0, m_pend == 2 && m_isalu});
      chk("carry", {31'b0, carry_flag}, {31'b0, m_cy});
      chk("illegal", {31'b0, illegal}, {31'b0, m_ill});
      chk("dbg_data", {16'b0, dbg_data}, {16'b0, m_reg[dbg_addr]});
      if (m_pend == 2 && m_isalu) begin
        chk("alu_op1", {16'b0, alu_op1}, {16'b0, m_op1});
        chk("alu_op2", {16'b0, alu_op2}, {16'b0, m_op2});
      end
      if (alu_en) en_cnt++;
    end
  end

  task automatic tick(output bit acc);
    @(posedge clk);
    acc = (m_pend == 0) && instr_valid && !rst;
    model_edge();
    nc = 1'($urandom);
    #1;
    dbg_addr = 3'($urandom);
  endtask

  task automatic issue(input logic [15:0] w, output int cyc);
    bit a;
    a = 0; cyc = 0;
    instr = w; instr_valid = 1'b1;
    while (!a && cyc < 20) begin
      tick(a);
      cyc++;
    end
    if (!a) chk("accept_timeout", 0, 1);
    instr_valid = 1'b0;
  endtask

  task automatic drain();
    bit a;
    int n;
    n = 0;
    while (m_pend != 0 && n < 10) begin tick(a); n++; end
    tick(a);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] addr, input logic [15:0] exp);
    dbg_addr = addr;
    #1;
    chk(name, {16'b0, dbg_data}, {16'b0, exp});
  endtask

  function automatic logic [15:0] enc(input int op, input int rd, input int r1, input int r2);
    return {op[2:0], rd[2:0], r1[2:0], r2[2:0], 4'b0000};
  endfunction

  function automatic logic [15:0] ldi(input int rd, input int imm);
    return {3'd6, rd[2:0], imm[9:0]};
  endfunction

  initial begin
    bit a;
    int c, e0;
    model_reset();
    chk_en = 1'b1;
    tick(a); tick(a);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) rd_chk("reset_reg", 3'(i), 16'h0000);
    chk("reset_ready", {31'b0, instr_ready}, 1);
    chk("reset_alu_en", {31'b0, alu_en}, 0);
    chk("reset_carry", {31'b0, carry_flag}, 0);

    // Add sequence with write-timing check
    issue(ldi(1, 10'h3FF), c);
    issue(ldi(2, 1), c);
    e0 = en_cnt;
    issue(enc(1, 3, 1, 2), c);
    rd_chk("r3_at_e0", 3, 16'h0000);
    tick(a);
    rd_chk("r3_at_e1", 3, 16'h0000);
    tick(a);
    rd_chk("r3_at_e2", 3, 16'h0400);
    chk("add_carry", {31'b0, carry_flag}, 0);
    chk("alu_en_cycles", en_cnt - e0, 1);

    // Overflow and compares
    issue(enc(5, 4, 0, 0), c); drain(); rd_chk("not_r4", 4, 16'hFFFF);
    issue(enc(1, 5, 4, 2), c); drain(); rd_chk("ovf_r5", 5, 16'h0000);
    chk("ovf_carry", {31'b0, carry_flag}, 1);
    issue(enc(2, 7, 2, 1), c); drain(); rd_chk("sub_r7", 7, 16'hFC02);
    chk("sub_carry", {31'b0, carry_flag}, 1);
    issue(enc(3, 6, 1, 2), c); drain(); rd_chk("gte_r6", 6, 16'h0001);
    chk("gte_carry", {31'b0, carry_flag}, 0);
    issue(enc(4, 6, 1, 2), c); drain(); rd_chk("lt_r6", 6, 16'h0000);
    issue(enc(1, 5, 4, 2), c); drain();
    issue(enc(5, 4, 1, 0), c); drain(); rd_chk("not_r4b", 4, 16'hFC00);
    chk("not_keeps_carry", {31'b0, carry_flag}, 1);

    // Boundaries
    issue(ldi(0, 5), c); drain(); rd_chk("r0_zero", 0, 16'h0000);
    issue(enc(7, 1, 0, 0), c); tick(a);
    chk("illegal_set", {31'b0, illegal}, 1);
    rd_chk("illegal_no_write", 1, 16'h03FF);
    issue(enc(0, 1, 0, 0), c); issue(enc(0, 2, 0, 0), c); tick(a);
    chk("illegal_sticky", {31'b0, illegal}, 1);

    // Backpressure: continuous valid over mixed traffic
    issue(enc(1, 3, 1, 2), c);
    issue(ldi(2, 7), c);        chk("gap_alu", c, 3);
    issue(enc(0, 0, 0, 0), c);  chk("gap_ldi", c, 2);
    issue(enc(0, 0, 0, 0), c);  chk("gap_nop", c, 1);
    issue(enc(2, 3, 1, 2), c);  chk("gap_nop2", c, 1);
    issue(ldi(1, 2), c);        chk("gap_sub", c, 3);
    drain();
    rd_chk("bp_r2", 2, 16'h0007);
    rd_chk("bp_r3", 3, 16'h03F8);
    rd_chk("bp_r1", 1, 16'h0002);

    // Reset during EXEC
    issue(enc(1, 3, 1, 2), c);
    rst = 1'b1;
    model_reset();
    #1;
    chk("rst_ready", {31'b0, instr_ready}, 1);
    chk("rst_alu_en", {31'b0, alu_en}, 0);
    tick(a); tick(a); tick(a);
    rst = 1'b0;
    rd_chk("rst_r3", 3, 16'h0000);
    chk("rst_illegal", {31'b0, illegal}, 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        issue(ldi($urandom_range(0, 7), $urandom_range(0, 1023)), c);
      else
        issue(enc($urandom_range(0, 7), $urandom_range(0, 7),
                  $urandom_range(0, 7), $urandom_range(0, 7)), c);
      if ($urandom_range(0, 4) == 0) begin
        instr = 16'($urandom);
        tick(a);
      end
    end
    drain();

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
